debug_dump_ctrl: RTL and testbench
==================================

# debug_dump_ctrl

Sequencer that streams the halted pipeline's architectural state to the UART transmitter after a debug run or step completes. On a start pulse it snapshots PC and cycle count, walks the register file and data memory through the pipeline's debug read ports, and serialises every 32-bit word as four bytes with a start/done handshake to the UART TX. It sits between `pipeline` and the UART TX inside `debug_unit`, and replaces the ad-hoc dump logic there.

## Interface
- `NB_DATA`, 32, width of register and memory words (fixed multiple of 8; 32 in this design)
- `NB_REG`, 5, register address width
- `N_REGS`, 32, registers dumped (addresses 0..N_REGS-1)
- `NB_ADDR`, 7, memory address, PC and cycle-count width
- `N_MEM_WORDS`, 32, data-memory words dumped (addresses 0..N_MEM_WORDS-1)

- `i_clock`  in  1  single clock
- `i_reset`  in  1  reset; synchronous, active-high
- `i_start`  in  1  request a dump; honoured only in IDLE
- `i_pc`  in  NB_ADDR  current PC; snapshotted when start is accepted
- `i_cycles`  in  NB_ADDR  cycle count; snapshotted when start is accepted
- `i_reg_data`  in  NB_DATA  register-file debug read data; valid 1 cycle after `o_reg_rd_en`
- `i_mem_data`  in  NB_DATA  data-memory debug read data; valid 1 cycle after `o_mem_rd_en`
- `i_tx_done`  in  1  UART TX finished current byte (1-cycle pulse)
- `o_addr_reg`  out  NB_REG  register debug read address
- `o_reg_rd_en`  out  1  register debug read strobe
- `o_addr_mem`  out  NB_ADDR  memory debug read address
- `o_mem_rd_en`  out  1  memory debug read strobe
- `o_tx_start`  out  1  1-cycle pulse: send `o_tx_data`
- `o_tx_data`  out  8  byte to transmit
- `o_busy`  out  1  dump in progress
- `o_done`  out  1  1-cycle pulse after the last byte completes

## Operation
- Stream order: PC word, cycle word, reg 0..N_REGS-1, mem 0..N_MEM_WORDS-1. PC and cycles are zero-extended to 32 bits. Each word is sent LSB byte first.
- Total bytes: 4*(2+N_REGS+N_MEM_WORDS). With the defaults this is 264.
- State machine: IDLE, SEND, WAIT_TX, REQ_REG, WAIT_REG, REQ_MEM, WAIT_MEM, DONE.
- Internal registers: 32-bit shift register `word`, 2-bit byte index, word index, source select (PC/CYC/REG/MEM), cycle snapshot.
- IDLE + i_start:
  - load `word`<=zext(i_pc) and the cycle snapshot <=i_cycles
  - byte index <=0
  - go to SEND
- SEND: assert `o_tx_start` for one cycle; `o_tx_data`=word[7:0]. Go to WAIT_TX.
- WAIT_TX + i_tx_done, byte index <3: shift `word` right 8, byte index++, go to SEND.
- WAIT_TX + i_tx_done, byte index ==3 (advance source):
  - PC -> load the cycle snapshot into `word`, go to SEND
  - CYC -> reg index 0, go to REQ_REG
  - REG, index<N_REGS-1 -> index++, go to REQ_REG
  - last REG -> mem index 0, go to REQ_MEM
  - MEM, index<N_MEM_WORDS-1 -> index++, go to REQ_MEM
  - last MEM -> go to DONE
- REQ_REG: `o_reg_rd_en`=1, `o_addr_reg`=index, go to WAIT_REG. WAIT_REG: `word`<=i_reg_data, go to SEND. REQ_MEM/WAIT_MEM behave the same way on the memory port.
- DONE: `o_done`=1 for one cycle, go to IDLE.
- Byte index resets to 0 on every word load.
- `o_addr_reg`/`o_addr_mem` hold their last value outside the read strobes. They are 0 after reset.

## Timing
- All outputs are decoded from registered state only (Moore); no combinational path from inputs to outputs.
- Reset values:
  - all outputs 0
  - state IDLE
  - all indices 0
- Start latency: i_start high at cycle T -> `o_busy`=1 and `o_tx_start`=1 at T+1.
- Byte-to-byte gap inside a word: i_tx_done at cycle D -> next `o_tx_start` at D+1.
- Gap to the first byte of the next word:
  - D+1 for the cycle word
  - D+3 for REG/MEM words (REQ at D+1, WAIT at D+2, SEND at D+3)
- `o_tx_data` is stable from SEND through the end of WAIT_TX.
- `o_busy` is high in every state except IDLE, including DONE.
- i_start outside IDLE is ignored. i_tx_done outside WAIT_TX is ignored.
- i_reset during any state (mid-word, mid-read, DONE) -> IDLE with reset outputs on the next cycle; no o_done. A later i_start restarts from the PC word.
- i_reset and i_start in the same cycle: reset wins.

## Test plan
- Reset: hold i_reset with i_start=1 for 3 cycles -> all outputs 0, no o_tx_start; release -> nothing happens until a fresh i_start.
- Full dump (defaults), i_tx_done 2 cycles after each o_tx_start:
  - inputs: pc=0x05, cycles=0x1A, reg[i]=0x10000000+i, mem[j]=0xA0A00000+j
  - first 12 bytes must be 05 00 00 00 1A 00 00 00 00 00 00 10
  - exactly 264 o_tx_start pulses
  - o_done once, 1 cycle after the 264th i_tx_done
- Read ports:
  - o_addr_reg must step 0..31 with exactly one o_reg_rd_en per address
  - then o_addr_mem 0..31 with one o_mem_rd_en each
  - the byte after WAIT_REG must equal the low byte of i_reg_data
- Protocol noise: i_start pulsed mid-dump and i_tx_done pulsed in IDLE/SEND/REQ_REG -> stream and pulse count unchanged (264).
- Reset mid-dump after byte 50 -> IDLE and o_busy=0 next cycle; new i_start (pc=0x07) -> first byte 07, full 264 bytes follow.
- Slow UART: i_tx_done delayed 100 cycles -> single o_tx_start per byte, o_tx_data constant for all 100 cycles, and the PC and cycle bytes keep their values captured at start even though i_pc/i_cycles change mid-dump.

Source files
------------

// File: rtl/debug_dump_ctrl.sv
// Streams PC, cycle count, register file and data memory to the UART TX as
// little-endian byte sequences after a debug run/step halts the pipeline.
module debug_dump_ctrl #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int N_REGS      = 32,
    parameter int NB_ADDR     = 7,
    parameter int N_MEM_WORDS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_ADDR-1:0] i_cycles,
    input  logic [NB_DATA-1:0] i_reg_data,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic               i_tx_done,
    output logic [NB_REG-1:0]  o_addr_reg,
    output logic               o_reg_rd_en,
    output logic [NB_ADDR-1:0] o_addr_mem,
    output logic               o_mem_rd_en,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_dbg_state
);

    localparam int MAX_WORDS = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
    localparam int NB_IDX    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [NB_IDX-1:0] LAST_REG = NB_IDX'(N_REGS - 1);
    localparam logic [NB_IDX-1:0] LAST_MEM = NB_IDX'(N_MEM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_TX  = 3'd2,
        REQ_REG  = 3'd3,
        WAIT_REG = 3'd4,
        REQ_MEM  = 3'd5,
        WAIT_MEM = 3'd6,
        DONE     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SRC_PC  = 2'd0,
        SRC_CYC = 2'd1,
        SRC_REG = 2'd2,
        SRC_MEM = 2'd3
    } src_t;

    state_t               state, state_next;
    src_t                 src;
    logic [NB_DATA-1:0]   word;
    logic [1:0]           byte_idx;
    logic [NB_IDX-1:0]    word_idx;
    logic [NB_ADDR-1:0]   cyc_snap;
    logic [NB_REG-1:0]    addr_reg;
    logic [NB_ADDR-1:0]   addr_mem;
    logic                 last_word;

    // UART handshake: o_tx_start is a one-cycle request for o_tx_data; the
    // byte is owned by the TX until i_tx_done pulses, which only WAIT_TX heeds.
    assign last_word = ((src == SRC_REG) && (word_idx == LAST_REG)) ||
                       ((src == SRC_MEM) && (word_idx == LAST_MEM));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_start) state_next = SEND;
            SEND:     state_next = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) begin
                    if (byte_idx != 2'd3) begin
                        state_next = SEND;
                    end else begin
                        case (src)
                            SRC_PC:  state_next = SEND;
                            SRC_CYC: state_next = REQ_REG;
                            SRC_REG: state_next = last_word ? REQ_MEM : REQ_REG;
                            default: state_next = last_word ? DONE : REQ_MEM;
                        endcase
                    end
                end
            end
            REQ_REG:  state_next = WAIT_REG;
            WAIT_REG: state_next = SEND;
            REQ_MEM:  state_next = WAIT_MEM;
            WAIT_MEM: state_next = SEND;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= IDLE;
            src      <= SRC_PC;
            word     <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            cyc_snap <= '0;
            addr_reg <= '0;
            addr_mem <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        word     <= NB_DATA'(i_pc);
                        cyc_snap <= i_cycles;
                        byte_idx <= '0;
                        word_idx <= '0;
                        src      <= SRC_PC;
                    end
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (byte_idx != 2'd3) begin
                            word     <= word >> 8;
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            // Read addresses are set here so they are already
                            // stable when the strobe rises in REQ_*.
                            case (src)
                                SRC_PC: begin
                                    word     <= NB_DATA'(cyc_snap);
                                    byte_idx <= '0;
                                    src      <= SRC_CYC;
                                end
                                SRC_CYC: begin
                                    word_idx <= '0;
                                    addr_reg <= '0;
                                    src      <= SRC_REG;
                                end
                                SRC_REG: begin
                                    if (last_word) begin
                                        word_idx <= '0;
                                        addr_mem <= '0;
                                        src      <= SRC_MEM;
                                    end else begin
                                        word_idx <= word_idx + 1'b1;
                                        addr_reg <= NB_REG'(word_idx + 1'b1);
                                    end
                                end
                                default: begin
                                    if (!last_word) begin
                                        word_idx <= word_idx + 1'b1;
                                        addr_mem <= NB_ADDR'(word_idx + 1'b1);
                                    end
                                end
                            endcase
                        end
                    end
                end
                WAIT_REG: begin
                    word     <= i_reg_data;
                    byte_idx <= '0;
                end
                WAIT_MEM: begin
                    word     <= i_mem_data;
                    byte_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_tx_start  = (state == SEND);
    assign o_tx_data   = word[7:0];
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_reg_rd_en = (state == REQ_REG);
    assign o_mem_rd_en = (state == REQ_MEM);
    assign o_addr_reg  = addr_reg;
    assign o_addr_mem  = addr_mem;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Randomised bench for debug_dump_ctrl: a byte-stream reference model feeds
// expected queues that a negedge monitor drains as the DUT emits bytes/reads.
module tb_debug_dump_ctrl;

    localparam int NB_DATA     = 32;
    localparam int NB_REG      = 5;
    localparam int N_REGS      = 32;
    localparam int NB_ADDR     = 7;
    localparam int N_MEM_WORDS = 32;
    localparam int N_BYTES     = 4 * (2 + N_REGS + N_MEM_WORDS);

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_start = 1'b0;
    logic [NB_ADDR-1:0] i_pc = '0;
    logic [NB_ADDR-1:0] i_cycles = '0;
    logic [NB_DATA-1:0] i_reg_data = '0;
    logic [NB_DATA-1:0] i_mem_data = '0;
    logic               i_tx_done = 1'b0;
    logic [NB_REG-1:0]  o_addr_reg;
    logic               o_reg_rd_en;
    logic [NB_ADDR-1:0] o_addr_mem;
    logic               o_mem_rd_en;
    logic               o_tx_start;
    logic [7:0]         o_tx_data;
    logic               o_busy;
    logic               o_done;
    logic [2:0]         o_dbg_state;

    debug_dump_ctrl #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_REGS(N_REGS),
        .NB_ADDR(NB_ADDR), .N_MEM_WORDS(N_MEM_WORDS)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
        .i_pc(i_pc), .i_cycles(i_cycles),
        .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_tx_done(i_tx_done),
        .o_addr_reg(o_addr_reg), .o_reg_rd_en(o_reg_rd_en),
        .o_addr_mem(o_addr_mem), .o_mem_rd_en(o_mem_rd_en),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [NB_DATA-1:0] rf  [N_REGS];
    logic [NB_DATA-1:0] dm  [N_MEM_WORDS];
    logic [7:0]         exp_q[$];
    int                 gap_q[$];
    logic [NB_REG-1:0]  exp_reg_q[$];
    logic [NB_ADDR-1:0] exp_mem_q[$];
    int  tx_delay   = 2;
    bit  noise_en   = 1'b0;
    bit  uart_flush = 1'b0;
    int  start_cyc  = 0;
    int  last_done_cyc = 0;
    bit  tx_pending = 1'b0;
    logic [7:0] tx_byte = '0;
    int  done_cnt   = 0;
    int  bytes_sent = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the dump is just the word list PC, CYC, regs, mems,
    // each emitted as four little-endian bytes.
    task automatic load_model(input logic [NB_ADDR-1:0] pc, input logic [NB_ADDR-1:0] cv);
        logic [31:0] words[$];
        words.push_back(32'(pc));
        words.push_back(32'(cv));
        for (int i = 0; i < N_REGS; i++) words.push_back(rf[i]);
        for (int j = 0; j < N_MEM_WORDS; j++) words.push_back(dm[j]);
        for (int k = 0; k < words.size(); k++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'(words[k] >> (8 * b)));
                if (k == 0 && b == 0)      gap_q.push_back(-1);
                else if (b != 0 || k == 1) gap_q.push_back(1);
                else                       gap_q.push_back(3);
            end
        end
        for (int i = 0; i < N_REGS; i++) exp_reg_q.push_back(NB_REG'(i));
        for (int j = 0; j < N_MEM_WORDS; j++) exp_mem_q.push_back(NB_ADDR'(j));
    endtask

    // ---------------- UART TX responder ----------------
    initial begin
        int cd = 0;
        forever begin
            @(posedge clk); #1;
            i_tx_done = 1'b0;
            if (uart_flush) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) i_tx_done = 1'b1;
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                i_tx_done = 1'b1;
            end
            if (o_tx_start && !uart_flush) cd = tx_delay;
        end
    end

    // ---------------- debug read-port responder (1-cycle latency) ----------------
    initial begin
        bit pend_reg, pend_mem;
        logic [NB_REG-1:0]  ra;
        logic [NB_ADDR-1:0] ma;
        forever begin
            @(negedge clk);
            pend_reg = o_reg_rd_en; ra = o_addr_reg;
            pend_mem = o_mem_rd_en; ma = o_addr_mem;
            @(posedge clk); #1;
            i_reg_data = pend_reg ? rf[ra] : $urandom;
            i_mem_data = pend_mem ? dm[ma] : $urandom;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [7:0] eb;
        int g;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                tx_pending = 1'b0;
            end else begin
                if (tx_pending) begin
                    check("tx_data_stable", 32'(o_tx_data), 32'(tx_byte));
                    if (i_tx_done) begin
                        tx_pending = 1'b0;
                        last_done_cyc = cyc;
                    end
                end
                if (o_tx_start) begin
                    check("single_tx_start", 32'(tx_pending), 32'd0);
                    check("tx_start_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        eb = exp_q.pop_front();
                        g  = gap_q.pop_front();
                        check("tx_byte", 32'(o_tx_data), 32'(eb));
                        if (g < 0) check("first_byte_latency", 32'(cyc - start_cyc), 32'd1);
                        else       check("byte_gap", 32'(cyc - last_done_cyc), 32'(g));
                    end
                    tx_pending = 1'b1;
                    tx_byte    = o_tx_data;
                    bytes_sent++;
                end
                if (o_reg_rd_en) begin
                    check("reg_rd_expected", 32'(exp_reg_q.size() > 0), 32'd1);
                    if (exp_reg_q.size() > 0)
                        check("reg_rd_addr", 32'(o_addr_reg), 32'(exp_reg_q.pop_front()));
                end
                if (o_mem_rd_en) begin
                    check("mem_rd_expected", 32'(exp_mem_q.size() > 0), 32'd1);
                    if (exp_mem_q.size() > 0)
                        check("mem_rd_addr", 32'(o_addr_mem), 32'(exp_mem_q.pop_front()));
                end
                if (o_done) begin
                    check("done_all_bytes_sent", 32'(exp_q.size()), 32'd0);
                    check("done_latency", 32'(cyc - last_done_cyc), 32'd1);
                    done_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(o_busy), 0);
        check({tag, "_tx_start"}, 32'(o_tx_start), 0);
        check({tag, "_tx_data"},  32'(o_tx_data), 0);
        check({tag, "_done"},     32'(o_done), 0);
        check({tag, "_reg_rd"},   32'(o_reg_rd_en), 0);
        check({tag, "_mem_rd"},   32'(o_mem_rd_en), 0);
        check({tag, "_addr_reg"}, 32'(o_addr_reg), 0);
        check({tag, "_addr_mem"}, 32'(o_addr_mem), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_REGS; i++) rf[i] = $urandom;
        for (int j = 0; j < N_MEM_WORDS; j++) dm[j] = $urandom;
    endtask

    task automatic flush_queues();
        exp_q.delete(); gap_q.delete(); exp_reg_q.delete(); exp_mem_q.delete();
    endtask

    task automatic apply_reset();
        int d0 = done_cnt;
        @(posedge clk); #1;
        i_reset = 1'b1; i_start = 1'b0; uart_flush = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        flush_queues();
        @(negedge clk);
        check("busy_after_reset", 32'(o_busy), 0);
        check("tx_start_after_reset", 32'(o_tx_start), 0);
        @(posedge clk); #1;
        uart_flush = 1'b0;
        repeat (4) @(negedge clk);
        check("no_done_after_reset", 32'(done_cnt - d0), 0);
    endtask

    task automatic run_dump(input logic [NB_ADDR-1:0] pc, input logic [NB_ADDR-1:0] cv,
                            input int delay, input bit noise, input bit start_noise,
                            input bit wiggle, input int abort_after);
        int base_done  = done_cnt;
        int base_bytes = bytes_sent;
        int budget     = N_BYTES * (delay + 4) + 100;
        bit finished   = 1'b0;
        bit aborted    = 1'b0;
        tx_delay = delay;
        noise_en = noise;
        load_model(pc, cv);
        repeat (3) @(posedge clk);
        #1;
        i_pc = pc; i_cycles = cv; i_start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        check("busy_before_start_edge", 32'(o_busy), 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(o_busy), 1);
        for (int k = 0; k < budget && !finished && !aborted; k++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (done_cnt != base_done) finished = 1'b1;
            else if (abort_after > 0 && bytes_sent - base_bytes >= abort_after) aborted = 1'b1;
            else begin
                if (start_noise && $urandom_range(0, 9) == 0) i_start = 1'b1;
                if (wiggle) begin
                    i_pc = NB_ADDR'($urandom);
                    i_cycles = NB_ADDR'($urandom);
                end
            end
        end
        noise_en = 1'b0;
        if (aborted) begin
            apply_reset();
        end else begin
            check("dump_completed", 32'(finished), 1);
            repeat (5) @(negedge clk);
            check("done_pulse_count", 32'(done_cnt - base_done), 1);
            check("bytes_per_dump", 32'(bytes_sent - base_bytes), 32'(N_BYTES));
            check("stream_drained", 32'(exp_q.size()), 0);
            check("reg_reads_drained", 32'(exp_reg_q.size()), 0);
            check("mem_reads_drained", 32'(exp_mem_q.size()), 0);
            check("busy_idle", 32'(o_busy), 0);
            check("addr_reg_hold", 32'(o_addr_reg), 32'(N_REGS - 1));
            check("addr_mem_hold", 32'(o_addr_mem), 32'(N_MEM_WORDS - 1));
            if (!finished) apply_reset();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        i_reset = 1'b1;
        i_start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_no_busy", 32'(o_busy), 0);
            check("idle_no_tx_start", 32'(o_tx_start), 0);
        end

        // Reference dump with recognisable data.
        for (int i = 0; i < N_REGS; i++) rf[i] = 32'h1000_0000 + 32'(i);
        for (int j = 0; j < N_MEM_WORDS; j++) dm[j] = 32'hA0A0_0000 + 32'(j);
        run_dump(7'h05, 7'h1A, 2, 1'b0, 1'b0, 1'b0, 0);

        // Random data, random UART latency, with protocol noise.
        fill_random();
        run_dump(NB_ADDR'($urandom), NB_ADDR'($urandom), $urandom_range(1, 4), 1'b1, 1'b1, 1'b0, 0);

        // Reset mid-dump, then restart from the PC word.
        fill_random();
        run_dump(NB_ADDR'($urandom), NB_ADDR'($urandom), 2, 1'b0, 1'b0, 1'b0, 50);
        fill_random();
        run_dump(7'h07, NB_ADDR'($urandom), $urandom_range(1, 3), 1'b0, 1'b0, 1'b0, 0);

        // Slow UART with PC/cycles changing under the dump.
        fill_random();
        run_dump(7'h33, 7'h4C, 100, 1'b0, 1'b0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
